// File: rtl/saes_pkg.sv
// rtl/saes_pkg.sv - shared types, round constants and S-AES helper functions
// Purpose: FSM state enum, default round constants, and the ShiftRows /
//          nibble-rotate / GF(2^4) multiply-by-4 / MixColumns helpers used by
//          the round controller and the MixColumns sub-module.
// Ports:   none (package).
package saes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY1 = 3'd1,
        KEY2 = 3'd2,
        RND1 = 3'd3,
        RND2 = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [7:0] SAES_RCON1 = 8'h80;
    localparam logic [7:0] SAES_RCON2 = 8'h30;

    // Swap the two nibbles of the bottom row of the 2x2 state: [11:8] <-> [3:0].
    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [7:0] rot_nib(input logic [7:0] w);
        return {w[3:0], w[7:4]};
    endfunction

    // Multiply by x in GF(2^4), reducing by x^4 + x + 1.
    function automatic logic [3:0] gf4_xtime(input logic [3:0] n);
        return {n[2:0], 1'b0} ^ (n[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf4_mul4(input logic [3:0] n);
        return gf4_xtime(gf4_xtime(n));
    endfunction

    // Columns are (n0,n1) = [15:12],[11:8] and (n2,n3) = [7:4],[3:0].
    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {s[15:12] ^ gf4_mul4(s[11:8]),
                gf4_mul4(s[15:12]) ^ s[11:8],
                s[7:4] ^ gf4_mul4(s[3:0]),
                gf4_mul4(s[7:4]) ^ s[3:0]};
    endfunction

endpackage

// File: rtl/saes_round_ctrl_if.sv
// rtl/saes_round_ctrl_if.sv - handshake and subbytes bus of the round controller
// Purpose: groups the plaintext/key input handshake, the ciphertext output
//          handshake, the shared subbytes operand/result pair and busy.
// Modports: master - block source / ciphertext consumer / subbytes owner
//           slave  - the round controller
interface saes_round_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] plaintext;
    logic [15:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ciphertext;
    logic [15:0] sb_in;
    logic [15:0] sb_out;
    logic        busy;

    modport master (
        output in_valid, plaintext, key, out_ready, sb_out,
        input  in_ready, out_valid, ciphertext, sb_in, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready, sb_out,
        output in_ready, out_valid, ciphertext, sb_in, busy
    );

endinterface

// File: rtl/saes_mixcol.sv
// rtl/saes_mixcol.sv - combinational 16-bit S-AES MixColumns
// Purpose: applies MixColumns (matrix [1 4; 4 1] over GF(2^4)) to a state.
// Ports:   i_data - 16-bit state in
//          o_data - 16-bit mixed state out
module saes_mixcol
    import saes_pkg::*;
(
    input  logic [15:0] i_data,
    output logic [15:0] o_data
);

    assign o_data = mix_col(i_data);

endmodule

// File: rtl/saes_subbytes.sv
// rtl/saes_subbytes.sv - combinational 16-bit S-AES SubNibbles (four 4-bit sboxes)
// Purpose: the shared substitution instance driven by the round controller.
// Ports:   i_data - operand (sb_in)
//          o_data - substituted result (sb_out), same cycle
module saes_subbytes (
    input  logic [15:0] i_data,
    output logic [15:0] o_data
);

    function automatic logic [3:0] sbox(input logic [3:0] n);
        case (n)
            4'h0: return 4'h9;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'hB;
            4'h4: return 4'hD;  4'h5: return 4'h1;  4'h6: return 4'h8;  4'h7: return 4'h5;
            4'h8: return 4'h6;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'h3;
            4'hC: return 4'hC;  4'hD: return 4'hE;  4'hE: return 4'hF;  default: return 4'h7;
        endcase
    endfunction

    assign o_data = {sbox(i_data[15:12]), sbox(i_data[11:8]),
                     sbox(i_data[7:4]),   sbox(i_data[3:0])};

endmodule

// File: rtl/saes_round_ctrl.sv
// rtl/saes_round_ctrl.sv - iterative 2-round S-AES encryption sequencer
// Purpose: accepts plaintext/key, time-multiplexes one external subbytes
//          instance across key expansion (KEY1, KEY2) and the two rounds
//          (RND1, RND2), then holds the ciphertext until it is consumed.
// Ports:   clk - rising-edge clock
//          rst - asynchronous active-high reset
//          bus - saes_round_ctrl_if.slave (in/out handshakes, sb_in/sb_out, busy)
// Config:  SAES_KEY_CACHE_EN - cache the last expanded key; a repeated key
//          skips KEY1/KEY2 (IDLE -> RND1).
module saes_round_ctrl
    import saes_pkg::*;
#(
    parameter logic [7:0] RCON1 = SAES_RCON1,
    parameter logic [7:0] RCON2 = SAES_RCON2
) (
    input  logic                  clk,
    input  logic                  rst,
    saes_round_ctrl_if.slave      bus
);

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_w0, r_w1, r_w2, r_w3, r_w4, r_w5;
    logic [15:0] r_st;
    logic [15:0] r_ct;
    logic        r_out_valid;

    logic [7:0]  w_w2, w_w3, w_w4, w_w5;
    logic [15:0] w_sr;
    logic [15:0] w_mix;
    logic        w_cache_hit;

    // Key words: only the rotated/substituted upper byte of sb_out is used
    // during expansion; the lower byte of sb_in is driven to zero.
    assign w_w2 = r_w0 ^ RCON1 ^ bus.sb_out[15:8];
    assign w_w3 = w_w2 ^ r_w1;
    assign w_w4 = r_w2 ^ RCON2 ^ bus.sb_out[15:8];
    assign w_w5 = w_w4 ^ r_w3;

    assign w_sr = shift_rows(bus.sb_out);

    saes_mixcol u_mixcol (
        .i_data (w_sr),
        .o_data (w_mix)
    );

`ifdef SAES_KEY_CACHE_EN
    logic [15:0] r_cache_key;
    logic        r_cache_vld;

    // w2..w5 still hold the expansion of r_cache_key, so a hit can go
    // straight to the first round.
    assign w_cache_hit = r_cache_vld && (bus.key == r_cache_key);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cache_key <= 16'h0000;
            r_cache_vld <= 1'b0;
        end else if (r_state == KEY2) begin
            r_cache_key <= {r_w0, r_w1};
            r_cache_vld <= 1'b1;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.in_valid) w_next = w_cache_hit ? RND1 : KEY1;
            KEY1: w_next = KEY2;
            KEY2: w_next = RND1;
            RND1: w_next = RND2;
            RND2: w_next = DONE;
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (r_state == IDLE);
        bus.busy     = (r_state != IDLE);
        bus.sb_in    = 16'h0000;
        case (r_state)
            KEY1:       bus.sb_in = {rot_nib(r_w1), 8'h00};
            KEY2:       bus.sb_in = {rot_nib(r_w3), 8'h00};
            RND1, RND2: bus.sb_in = r_st;
            default:    bus.sb_in = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w0        <= 8'h00;
            r_w1        <= 8'h00;
            r_w2        <= 8'h00;
            r_w3        <= 8'h00;
            r_w4        <= 8'h00;
            r_w5        <= 8'h00;
            r_st        <= 16'h0000;
            r_ct        <= 16'h0000;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_w0 <= bus.key[15:8];
                        r_w1 <= bus.key[7:0];
                        r_st <= bus.plaintext ^ bus.key;
                    end
                end
                KEY1: begin
                    r_w2 <= w_w2;
                    r_w3 <= w_w3;
                end
                KEY2: begin
                    r_w4 <= w_w4;
                    r_w5 <= w_w5;
                end
                RND1: r_st <= {r_w2, r_w3} ^ w_mix;
                RND2: begin
                    r_ct        <= {r_w4, r_w5} ^ w_sr;
                    r_out_valid <= 1'b1;
                end
                DONE: if (bus.out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.ciphertext = r_ct;

endmodule

// File: tb/tb_saes_round_ctrl.sv
// tb/tb_saes_round_ctrl.sv - directed self-checking bench for saes_round_ctrl
module tb_saes_round_ctrl;
    import saes_pkg::*;

    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_bad;

    saes_round_ctrl_if bus_if ();

    saes_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    saes_subbytes u_sb (
        .i_data (bus_if.sb_in),
        .o_data (bus_if.sb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached without finishing");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE. Returns at the negedge where
    // out_valid is first seen; lat counts the accept cycle as cycle 1.
    task automatic send_block(input logic [15:0] pt, input logic [15:0] k,
                              output int lat, output logic ok,
                              output logic [15:0] sb_first, output int rdy_busy);
        bus_if.in_valid  = 1'b1;
        bus_if.plaintext = pt;
        bus_if.key       = k;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        sb_first = bus_if.sb_in;
        lat = 1;
        ok = 1'b0;
        rdy_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (bus_if.in_ready) rdy_busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int          lat;
    logic        ok;
    logic [15:0] sbf;
    int          rb;
    int          a1, a2;
    logic [15:0] got1;
    logic        found;
    logic        stable;

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.plaintext = 16'h0000;
        bus_if.key       = 16'h0000;
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_in_ready",  bus_if.in_ready,   1);
        check("rst_out_valid", bus_if.out_valid,  0);
        check("rst_busy",      bus_if.busy,       0);
        check("rst_ct",        bus_if.ciphertext, 16'h0000);
        check("rst_sb_in",     bus_if.sb_in,      16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Standard vector
        bus_if.out_ready = 1'b1;
        send_block(16'h6F6B, 16'hA73B, lat, ok, sbf, rb);
        check("std_done",    ok, 1);
        check("std_latency", lat, 5);
        check("std_ct",      bus_if.ciphertext, 16'h0738);
        check("std_k1",      {dut.r_w2, dut.r_w3}, 16'h1C27);
        check("std_k2",      {dut.r_w4, dut.r_w5}, 16'h7651);
        check("std_sb_key1", sbf, 16'hB300);
        check("std_rdy_busy", rb, 0);
        check("done_sb_in",  bus_if.sb_in, 16'h0000);
        @(negedge clk);
        check("std_idle_rdy", bus_if.in_ready, 1);
        check("std_idle_ov",  bus_if.out_valid, 0);
        check("idle_sb_in",   bus_if.sb_in, 16'h0000);

        // Backpressure
        bus_if.out_ready = 1'b0;
        send_block(16'h6F6B, 16'hA73B, lat, ok, sbf, rb);
        check("bp_done", ok, 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.out_valid !== 1'b1 || bus_if.ciphertext !== 16'h0738
                || bus_if.in_ready !== 1'b0 || bus_if.sb_in !== 16'h0000)
                stable = 1'b0;
            @(negedge clk);
        end
        check("bp_stable", stable, 1);
        check("bp_ct", bus_if.ciphertext, 16'h0738);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", bus_if.in_ready, 1);
        check("bp_release_ov",  bus_if.out_valid, 0);

        // Reset during RND1
        bus_if.in_valid  = 1'b1;
        bus_if.plaintext = 16'h6F6B;
        bus_if.key       = 16'hA73B;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rnd1_busy", bus_if.busy, 1);
        check("rnd1_sb_in", bus_if.sb_in, 16'h0000 ^ dut.r_st);
        #1 rst = 1'b1;
        #1;
        check("abort_ov",   bus_if.out_valid, 0);
        check("abort_busy", bus_if.busy, 0);
        check("abort_rdy",  bus_if.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_block(16'h6F6B, 16'hA73B, lat, ok, sbf, rb);
        check("post_rst_done", ok, 1);
        check("post_rst_lat",  lat, 5);
        check("post_rst_ct",   bus_if.ciphertext, 16'h0738);
        @(negedge clk);

        // Back-to-back with in_valid held high across the busy period
        pulse_reset();
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.plaintext = 16'h6F6B;
        bus_if.key       = 16'hA73B;
        a1 = cyc + 1;
        @(negedge clk);
        bus_if.plaintext = 16'h0000;
        bus_if.key       = 16'h0000;
        got1 = 16'h0000;
        found = 1'b0;
        a2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.out_valid) got1 = bus_if.ciphertext;
            if (bus_if.in_ready) begin
                a2 = cyc + 1;
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b2b_found",   found, 1);
        check("b2b_ct1",     got1, 16'h0738);
        check("b2b_spacing", a2 - a1, 6);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.out_valid) begin
                ok = 1'b1;
                break;
            end
            check("b2b_rdy_busy", bus_if.in_ready, 0);
            @(negedge clk);
        end
        check("b2b_done2", ok, 1);
        check("b2b_ct2",   bus_if.ciphertext, 16'h071E);
        check("b2b_k1_zero", {dut.r_w2, dut.r_w3}, 16'h1919);
        check("b2b_k2_zero", {dut.r_w4, dut.r_w5}, 16'h0D14);
        @(negedge clk);

        // Repeated key
        pulse_reset();
        send_block(16'h6F6B, 16'hA73B, lat, ok, sbf, rb);
        check("rep1_lat", lat, 5);
        @(negedge clk);
        send_block(16'h6F6B, 16'hA73B, lat, ok, sbf, rb);
        check("rep2_done", ok, 1);
        check("rep2_ct",   bus_if.ciphertext, 16'h0738);
`ifdef SAES_KEY_CACHE_EN
        check("cache_hit_lat", lat, 3);
`else
        check("nocache_lat", lat, 5);
`endif
        @(negedge clk);
        send_block(16'h6F6B, 16'hA73C, lat, ok, sbf, rb);
        check("newkey_done", ok, 1);
        check("newkey_lat",  lat, 5);
        @(negedge clk);
        send_block(16'h6F6B, 16'hA73B, lat, ok, sbf, rb);
        check("oldkey_lat", lat, 5);
        check("oldkey_ct",  bus_if.ciphertext, 16'h0738);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/saes_round_ctrl.md
Name: saes_round_ctrl

Overview:
- Iterative simplified-AES (16-bit block, 16-bit key, 2 rounds) encryption sequencer.
- Owns the schedule for one external, shared, purely combinational 16-bit subbytes instance (four 4-bit sboxes).
- Time-multiplexes that instance between key expansion and the two cipher rounds.
- Accepts plaintext and key over a valid/ready handshake and returns ciphertext over a valid/ready handshake.

Parameters:
- RCON1, 8'h80, round constant XORed into key word w2.
- RCON2, 8'h30, round constant XORed into key word w4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  controller can accept.
- plaintext  input  16  block to encrypt, nibble 0 = [15:12].
- key  input  16  cipher key.
- out_valid  output  1  ciphertext held valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  16  encrypted block.
- sb_in  output  16  operand driven to the shared subbytes instance.
- sb_out  input  16  subbytes result, same cycle, combinational.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; ciphertext=0; sb_in=0; internal state/key registers=0.
- FSM states: IDLE, KEY1, KEY2, RND1, RND2, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture w0=key[15:8], w1=key[7:0], st=plaintext^key (round-0 AddRoundKey).
  - Go to KEY1.
- KEY1:
  - sb_in={w1[3:0],w1[7:4],8'h00}.
  - w2=w0^RCON1^sb_out[15:8]; w3=w2^w1. Register both.
  - Go to KEY2.
- KEY2:
  - sb_in={w3[3:0],w3[7:4],8'h00}.
  - w4=w2^RCON2^sb_out[15:8]; w5=w4^w3. Register both.
  - Go to RND1.
- RND1:
  - sb_in=st.
  - st = {w2,w3} ^ MixCol(ShiftRows(sb_out)).
  - Go to RND2.
- RND2:
  - sb_in=st.
  - ciphertext = {w4,w5} ^ ShiftRows(sb_out).
  - out_valid=1 registered. Go to DONE.
- DONE:
  - Hold ciphertext and out_valid stable while out_ready=0.
  - When out_ready=1: clear out_valid, go to IDLE.
- ShiftRows: swap nibbles [11:8] and [3:0].
- MixCol: per column (n0,n1) -> (n0 ^ 4*n1, 4*n0 ^ n1), arithmetic in GF(2^4) mod x^4+x+1.
- sb_in outside KEY1/KEY2/RND1/RND2 = 16'h0000.
- Latency: accept edge to out_valid = 5 cycles.
- Throughput: one block per 6 cycles minimum, since in_ready is asserted only in IDLE.
- in_valid while not IDLE is ignored; the source must hold it, per the handshake.
- rst during any state aborts the operation immediately. No partial output is produced and out_valid drops asynchronously.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: SAES_KEY_CACHE_EN.
- Defined:
  - Keep the expanded key w2..w5 plus a cached-key register and a cache_vld flag (reset 0).
  - On accept, if cache_vld and key equals the cached key, go IDLE->RND1 directly. Latency is 3 cycles.
  - Otherwise run the full expansion, then set cache_vld and store the key.
- Undefined:
  - Every block runs KEY1/KEY2. No cache registers exist.

Decomposition:
- Package saes_pkg:
  - FSM state enum.
  - RCON defaults.
  - Functions shift_rows, rot_nib, gf4_mul4 and mix_col.
- One sub-module, saes_mixcol: combinational 16-bit MixColumns, reused later by the decrypt path.
- The subbytes instance stays outside this block. The bench instantiates the existing subbytes module on sb_in/sb_out.

Test Plan:
- Standard vector: plaintext=16'h6F6B, key=16'hA73B, out_ready=1.
  - ciphertext=16'h0738.
  - out_valid exactly 5 cycles after accept.
  - Internal keys K1=16'h1C27 and K2=16'h7651.
- Backpressure: same vector, out_ready held 0 for 10 cycles.
  - out_valid and ciphertext=16'h0738 stay stable.
  - in_ready=0 throughout.
  - Return to IDLE one cycle after out_ready=1.
- Reset mid-operation: assert rst while in RND1.
  - Immediately out_valid=0, busy=0, in_ready=1.
  - Next block (6F6B/A73B) still yields 16'h0738.
- Back-to-back: two blocks, second with plaintext=16'h0000 and key=16'h0000.
  - Each result matches the bench's golden model.
  - in_ready only in IDLE.
  - 6-cycle spacing between blocks.
- SB port check: during KEY1 of the standard vector, sb_in=16'hB300.
  - sb_in is 0 in IDLE and DONE.
- SAES_KEY_CACHE_EN: encrypt 6F6B/A73B twice.
  - Second block latency is 3 cycles and result is 0738.
  - Changing the key to 16'hA73C forces 5-cycle latency.
